// File: rtl/cdi_bus_pkg.sv
// cdi_bus_pkg: SCC68070 bus memory map, decode targets and controller states.
package cdi_bus_pkg;
    localparam logic [23:0] MCD212_LO_END  = 24'h27FFFF;
    localparam logic [23:0] MCD212_HI_BASE = 24'h400000;
    localparam logic [23:0] MCD212_HI_END  = 24'h5FFFFF;
    localparam logic [7:0]  CDIC_PAGE      = 8'h30;
    localparam logic [7:0]  SLAVE_PAGE     = 8'h31;
    localparam logic [7:0]  NVRAM_PAGE     = 8'h32;
    localparam logic [23:0] ERR1_BASE      = 24'h600000;
    localparam logic [23:0] ERR1_END       = 24'hCFFFFF;
    localparam logic [23:0] ERR2_BASE      = 24'hF00000;
    typedef enum logic [2:0] {TGT_NONE, TGT_MCD212, TGT_CDIC, TGT_SLAVE, TGT_NVRAM, TGT_ERR} bus_target_e;
    typedef enum logic [1:0] {IDLE, ACTIVE, TERM} bus_state_e;
endpackage

// File: rtl/attex_bus_if.sv
// attex_bus_if: CPU strobes/address, target data/acks and the controller's selects and handshakes.
interface attex_bus_if;
    logic        as, uds, lds, write_strobe, iack4;
    logic [22:0] addr;
    logic [15:0] mcd212_dout, cdic_dout;
    logic [7:0]  slave_dout, nvram_dout;
    logic        mcd212_ack, cdic_ack, slave_ack, nvram_ack;
    logic        cs_mcd212, cs_cdic, cs_slave, cs_nvram;
    logic [15:0] data_in;
    logic        bus_ack, bus_err;
    modport slave (
        input  as, uds, lds, write_strobe, iack4, addr,
        input  mcd212_dout, cdic_dout, slave_dout, nvram_dout,
        input  mcd212_ack, cdic_ack, slave_ack, nvram_ack,
        output cs_mcd212, cs_cdic, cs_slave, cs_nvram, data_in, bus_ack, bus_err
    );
    modport master (
        output as, uds, lds, write_strobe, iack4, addr,
        output mcd212_dout, cdic_dout, slave_dout, nvram_dout,
        output mcd212_ack, cdic_ack, slave_ack, nvram_ack,
        input  cs_mcd212, cs_cdic, cs_slave, cs_nvram, data_in, bus_ack, bus_err
    );
endinterface

// File: rtl/attex_addr_decode.sv
// attex_addr_decode: maps a CPU word address to its bus target; forbidden regions win over every window.
module attex_addr_decode
    import cdi_bus_pkg::*;
(
    input  logic [22:0]  addr,
    output bus_target_e  tgt
);
    logic [23:0] w_a;
    assign w_a = {addr, 1'b0};
    always_comb
        tgt = ((w_a >= ERR1_BASE && w_a <= ERR1_END) || w_a >= ERR2_BASE) ? TGT_ERR :
              (w_a <= MCD212_LO_END || (w_a >= MCD212_HI_BASE && w_a <= MCD212_HI_END)) ? TGT_MCD212 :
              (w_a[23:16] == CDIC_PAGE)  ? TGT_CDIC :
              (w_a[23:16] == SLAVE_PAGE) ? TGT_SLAVE :
              (w_a[23:16] == NVRAM_PAGE) ? TGT_NVRAM : TGT_NONE;
endmodule

// File: rtl/attex_bus_ctrl.sv
// attex_bus_ctrl: SCC68070 bus controller -- chip selects, read mux, ack/timeout/bus-error FSM, fault log.
module attex_bus_ctrl
    import cdi_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int FAULT_CNT_W    = 8
) (
    input  logic                   clk30,
    input  logic                   reset,
    attex_bus_if.slave             bus,
    output logic [23:0]            fault_addr,
    output logic [FAULT_CNT_W-1:0] fault_cnt
);
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);
    bus_target_e w_tgt, w_sel;
    bus_state_e  r_state, w_nxt;
    logic [9:0]  r_cnt;
    logic        r_ack, r_err, w_live, w_tgt_ack, w_ack, w_err;
    attex_addr_decode u_dec (.addr(bus.addr), .tgt(w_tgt));
    assign w_sel         = bus.as ? w_tgt : TGT_NONE;
    assign bus.cs_mcd212 = w_sel == TGT_MCD212;
    assign bus.cs_cdic   = w_sel == TGT_CDIC;
    assign bus.cs_slave  = w_sel == TGT_SLAVE;
    assign bus.cs_nvram  = w_sel == TGT_NVRAM;
    // A cycle is live from the strobe cycle in IDLE until it terminates or as drops.
    assign w_live = (r_state == IDLE && bus.as && (bus.uds || bus.lds)) || (r_state == ACTIVE && bus.as);
    assign w_tgt_ack = bus.iack4 || (bus.cs_mcd212 && bus.mcd212_ack) || (bus.cs_cdic && bus.cdic_ack) ||
                       (bus.cs_slave && bus.slave_ack) || (bus.cs_nvram && (bus.nvram_ack || bus.write_strobe));
    assign w_ack = w_live && w_tgt_ack;
    assign w_err = w_live && !w_tgt_ack && (w_sel == TGT_ERR || (r_state == ACTIVE && r_cnt == TO_LAST));
    always_comb begin
        bus.data_in = bus.iack4 ? bus.cdic_dout :
                      bus.cs_mcd212 ? bus.mcd212_dout :
                      bus.cs_cdic ? bus.cdic_dout :
                      bus.cs_slave ? {bus.slave_dout, bus.slave_dout} :
                      bus.cs_nvram ? {bus.nvram_dout, bus.nvram_dout} : 16'h0000;
        bus.bus_ack = (r_state == TERM) ? r_ack : w_ack;
        bus.bus_err = (r_state == TERM) ? r_err : w_err;
        w_nxt = (r_state == TERM) ? (bus.as ? TERM : IDLE) :
                (w_ack || w_err) ? TERM :
                w_live ? ACTIVE : IDLE;
    end
    always_ff @(posedge clk30) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            fault_addr <= '0;
            fault_cnt  <= '0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= (r_state == ACTIVE && w_nxt == ACTIVE) ? r_cnt + 10'd1 : '0;
            if (r_state != TERM) begin
                r_ack <= w_ack;
                r_err <= w_err;
            end
            if (w_err) begin
                fault_addr <= {bus.addr, 1'b0};
                fault_cnt  <= (&fault_cnt) ? fault_cnt : fault_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_attex_bus_ctrl.sv
// tb_attex_bus_ctrl: directed scenario tests for attex_bus_ctrl with hand-computed expectations.
module tb_attex_bus_ctrl;
    logic        clk30 = 1'b0;
    logic        reset;
    logic [23:0] fault_addr;
    logic [7:0]  fault_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;
    attex_bus_if bus ();
    attex_bus_ctrl #(.TIMEOUT_CYCLES(1023), .FAULT_CNT_W(8)) dut (
        .clk30(clk30), .reset(reset), .bus(bus), .fault_addr(fault_addr), .fault_cnt(fault_cnt)
    );
    always #5 clk30 = ~clk30;

    task automatic tick;
        @(posedge clk30);
        #1;
    endtask

    task automatic start(input logic [23:0] a, input logic wr);
        bus.addr = a[23:1];
        bus.as = 1'b1;
        bus.uds = 1'b1;
        bus.lds = 1'b1;
        bus.write_strobe = wr;
    endtask

    task automatic end_cyc;
        bus.as = 1'b0;
        bus.uds = 1'b0;
        bus.lds = 1'b0;
        bus.write_strobe = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        #1;
        n_cmp++; if (fault_addr !== 24'h0) begin n_bad++; $display("FAIL reset_fault_addr: got %h want 000000", fault_addr); end
        n_cmp++; if (fault_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_fault_cnt: got %0d want 0", fault_cnt); end
        n_cmp++; if ({bus.bus_ack, bus.bus_err} !== 2'b00) begin n_bad++; $display("FAIL reset_handshake: got %b want 00", {bus.bus_ack, bus.bus_err}); end
        n_cmp++; if ({bus.cs_mcd212, bus.cs_cdic, bus.cs_slave, bus.cs_nvram} !== 4'b0000) begin n_bad++; $display("FAIL reset_cs: got %b want 0000", {bus.cs_mcd212, bus.cs_cdic, bus.cs_slave, bus.cs_nvram}); end
        n_cmp++; if (bus.data_in !== 16'h0000) begin n_bad++; $display("FAIL reset_data_in: got %h want 0000", bus.data_in); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cdic_read;
        bus.cdic_dout = 16'hBEEF;
        start(24'h300010, 1'b0);
        #1;
        n_cmp++; if (bus.cs_cdic !== 1'b1) begin n_bad++; $display("FAIL cdic_cs: got %b want 1", bus.cs_cdic); end
        n_cmp++; if (bus.data_in !== 16'hBEEF) begin n_bad++; $display("FAIL cdic_data: got %h want beef", bus.data_in); end
        n_cmp++; if (bus.bus_ack !== 1'b0) begin n_bad++; $display("FAIL cdic_early_ack: got %b want 0", bus.bus_ack); end
        tick();
        tick();
        tick();
        bus.cdic_ack = 1'b1;
        #1;
        n_cmp++; if (bus.bus_ack !== 1'b1) begin n_bad++; $display("FAIL cdic_ack: got %b want 1", bus.bus_ack); end
        tick();
        bus.cdic_ack = 1'b0;
        tick();
        n_cmp++; if (bus.bus_ack !== 1'b1) begin n_bad++; $display("FAIL cdic_ack_held: got %b want 1", bus.bus_ack); end
        end_cyc();
        n_cmp++; if (bus.bus_ack !== 1'b0) begin n_bad++; $display("FAIL cdic_ack_release: got %b want 0", bus.bus_ack); end
        n_cmp++; if (fault_cnt !== 8'd0) begin n_bad++; $display("FAIL cdic_fault_cnt: got %0d want 0", fault_cnt); end
    endtask

    task automatic test_nvram;
        start(24'h320004, 1'b1);
        bus.lds = 1'b0;
        #1;
        n_cmp++; if (bus.cs_nvram !== 1'b1) begin n_bad++; $display("FAIL nvram_cs: got %b want 1", bus.cs_nvram); end
        n_cmp++; if (bus.bus_ack !== 1'b1) begin n_bad++; $display("FAIL nvram_write_ack: got %b want 1", bus.bus_ack); end
        tick();
        n_cmp++; if (bus.bus_ack !== 1'b1) begin n_bad++; $display("FAIL nvram_write_held: got %b want 1", bus.bus_ack); end
        end_cyc();
        bus.nvram_dout = 8'h5A;
        start(24'h320004, 1'b0);
        #1;
        n_cmp++; if (bus.bus_ack !== 1'b0) begin n_bad++; $display("FAIL nvram_read_early_ack: got %b want 0", bus.bus_ack); end
        n_cmp++; if (bus.data_in !== 16'h5A5A) begin n_bad++; $display("FAIL nvram_read_data: got %h want 5a5a", bus.data_in); end
        tick();
        bus.nvram_ack = 1'b1;
        #1;
        n_cmp++; if (bus.bus_ack !== 1'b1) begin n_bad++; $display("FAIL nvram_read_ack: got %b want 1", bus.bus_ack); end
        tick();
        bus.nvram_ack = 1'b0;
        end_cyc();
    endtask

    task automatic test_err_region;
        start(24'h700000, 1'b0);
        #1;
        n_cmp++; if ({bus.bus_err, bus.bus_ack} !== 2'b10) begin n_bad++; $display("FAIL err_first_cycle: got %b want 10", {bus.bus_err, bus.bus_ack}); end
        n_cmp++; if ({bus.cs_mcd212, bus.cs_cdic, bus.cs_slave, bus.cs_nvram} !== 4'b0000) begin n_bad++; $display("FAIL err_cs: got %b want 0000", {bus.cs_mcd212, bus.cs_cdic, bus.cs_slave, bus.cs_nvram}); end
        tick();
        n_cmp++; if (bus.bus_err !== 1'b1) begin n_bad++; $display("FAIL err_held: got %b want 1", bus.bus_err); end
        n_cmp++; if (fault_addr !== 24'h700000) begin n_bad++; $display("FAIL err_fault_addr: got %h want 700000", fault_addr); end
        n_cmp++; if (fault_cnt !== 8'd1) begin n_bad++; $display("FAIL err_fault_cnt: got %0d want 1", fault_cnt); end
        end_cyc();
    endtask

    task automatic test_timeout;
        logic early = 1'b0;
        start(24'hD00000, 1'b0);
        #1;
        early = bus.bus_err;
        for (int k = 1; k < 1023; k++) begin
            tick();
            early = early | bus.bus_err;
        end
        n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL timeout_early: got %b want 0", early); end
        tick();
        n_cmp++; if (bus.bus_err !== 1'b1) begin n_bad++; $display("FAIL timeout_err: got %b want 1", bus.bus_err); end
        tick();
        n_cmp++; if (fault_addr !== 24'hD00000) begin n_bad++; $display("FAIL timeout_fault_addr: got %h want d00000", fault_addr); end
        n_cmp++; if (fault_cnt !== 8'd2) begin n_bad++; $display("FAIL timeout_fault_cnt: got %0d want 2", fault_cnt); end
        end_cyc();
    endtask

    task automatic test_ack_vs_timeout;
        start(24'h100000, 1'b0);
        for (int k = 1; k < 1023; k++) tick();
        tick();
        bus.mcd212_ack = 1'b1;
        #1;
        n_cmp++; if ({bus.bus_ack, bus.bus_err} !== 2'b10) begin n_bad++; $display("FAIL ack_vs_timeout: got %b want 10", {bus.bus_ack, bus.bus_err}); end
        tick();
        bus.mcd212_ack = 1'b0;
        n_cmp++; if (fault_cnt !== 8'd2) begin n_bad++; $display("FAIL ack_vs_timeout_cnt: got %0d want 2", fault_cnt); end
        end_cyc();
    endtask

    task automatic test_iack;
        bus.cdic_dout = 16'h0040;
        bus.iack4 = 1'b1;
        start(24'hE00000, 1'b0);
        #1;
        n_cmp++; if (bus.data_in !== 16'h0040) begin n_bad++; $display("FAIL iack_data: got %h want 0040", bus.data_in); end
        n_cmp++; if ({bus.bus_ack, bus.bus_err} !== 2'b10) begin n_bad++; $display("FAIL iack_handshake: got %b want 10", {bus.bus_ack, bus.bus_err}); end
        tick();
        bus.iack4 = 1'b0;
        end_cyc();
        n_cmp++; if (fault_cnt !== 8'd2) begin n_bad++; $display("FAIL iack_fault_cnt: got %0d want 2", fault_cnt); end
    endtask

    task automatic test_abort;
        start(24'h310000, 1'b0);
        tick();
        tick();
        end_cyc();
        #1;
        n_cmp++; if ({bus.bus_ack, bus.bus_err} !== 2'b00) begin n_bad++; $display("FAIL abort_handshake: got %b want 00", {bus.bus_ack, bus.bus_err}); end
        n_cmp++; if (fault_cnt !== 8'd2) begin n_bad++; $display("FAIL abort_fault_cnt: got %0d want 2", fault_cnt); end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 300; i++) begin
            start(24'hF12344, 1'b0);
            tick();
            end_cyc();
            if (i == 251) begin
                n_cmp++; if (fault_cnt !== 8'd254) begin n_bad++; $display("FAIL sat_before: got %0d want 254", fault_cnt); end
            end
        end
        n_cmp++; if (fault_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_final: got %0d want 255", fault_cnt); end
        n_cmp++; if (fault_addr !== 24'hF12344) begin n_bad++; $display("FAIL sat_fault_addr: got %h want f12344", fault_addr); end
    endtask

    task automatic test_reset_mid;
        bus.slave_dout = 8'hA5;
        start(24'h310000, 1'b0);
        #1;
        n_cmp++; if (bus.cs_slave !== 1'b1) begin n_bad++; $display("FAIL slave_cs: got %b want 1", bus.cs_slave); end
        n_cmp++; if (bus.data_in !== 16'hA5A5) begin n_bad++; $display("FAIL slave_data: got %h want a5a5", bus.data_in); end
        tick();
        tick();
        reset = 1'b1;
        tick();
        n_cmp++; if ({bus.bus_ack, bus.bus_err} !== 2'b00) begin n_bad++; $display("FAIL rstmid_handshake: got %b want 00", {bus.bus_ack, bus.bus_err}); end
        n_cmp++; if (fault_cnt !== 8'd0) begin n_bad++; $display("FAIL rstmid_fault_cnt: got %0d want 0", fault_cnt); end
        n_cmp++; if (fault_addr !== 24'h0) begin n_bad++; $display("FAIL rstmid_fault_addr: got %h want 000000", fault_addr); end
        reset = 1'b0;
        bus.as = 1'b0;
        bus.uds = 1'b0;
        bus.lds = 1'b0;
        bus.slave_ack = 1'b1;
        #1;
        n_cmp++; if ({bus.bus_ack, bus.cs_slave} !== 2'b00) begin n_bad++; $display("FAIL rstmid_late_ack: got %b want 00", {bus.bus_ack, bus.cs_slave}); end
        tick();
        n_cmp++; if (bus.bus_ack !== 1'b0) begin n_bad++; $display("FAIL rstmid_late_ack_next: got %b want 0", bus.bus_ack); end
        bus.slave_ack = 1'b0;
    endtask

    initial begin
        {bus.as, bus.uds, bus.lds, bus.write_strobe, bus.iack4} = '0;
        bus.addr = '0;
        {bus.mcd212_dout, bus.cdic_dout, bus.slave_dout, bus.nvram_dout} = '0;
        {bus.mcd212_ack, bus.cdic_ack, bus.slave_ack, bus.nvram_ack} = '0;
        test_reset();
        test_cdic_read();
        test_nvram();
        test_err_region();
        test_timeout();
        test_ack_vs_timeout();
        test_iack();
        test_abort();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
